// File: rtl/pc_lut_pkg.sv
// Shared types and constants for the branch-target LUT loader.
package pc_lut_pkg;

  localparam int unsigned PC_LUT_D     = 10;
  localparam int unsigned PC_LUT_DEPTH = 32;
  localparam int unsigned ADDR_W       = 8;
  localparam int unsigned HDR_BYTES    = 1;
  localparam int unsigned ENTRY_BYTES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_LO,
    ST_HI,
    ST_CSUM,
    ST_DONE
  } loader_state_t;

  // States in which the loader consumes a stream byte
  function automatic logic accepts_bytes(input loader_state_t s);
    return (s == ST_COUNT) || (s == ST_LO) || (s == ST_HI) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/pc_lut_store.sv
// Branch-target table storage: synchronous write, one-cycle clear, async reset,
// combinational read returning 0 for out-of-range addresses.
module pc_lut_store
  import pc_lut_pkg::*;
#(
  parameter int unsigned D     = PC_LUT_D,
  parameter int unsigned DEPTH = PC_LUT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [D-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [D-1:0]      rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W = ADDR_W + 1;

  logic [D-1:0] mem_q [DEPTH];
  logic [D-1:0] mem_d [DEPTH];
  logic         waddr_ok;
  logic         raddr_ok;

  assign waddr_ok = ({1'b0, waddr} < CMP_W'(DEPTH));
  assign raddr_ok = ({1'b0, raddr} < CMP_W'(DEPTH));

  // Clear wins over a write issued in the same cycle
  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
    end else if (we && waddr_ok) begin
      mem_d[IDX_W'(waddr)] = wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = raddr_ok ? mem_q[IDX_W'(raddr)] : '0;

endmodule

// File: rtl/pc_lut_loader.sv
// Byte-stream writer for the branch-target LUT (header count + 2-byte entries).
// Optional trailing XOR checksum byte when PC_LUT_LOADER_CSUM_EN is defined.
module pc_lut_loader
  import pc_lut_pkg::*;
#(
  parameter int unsigned D     = PC_LUT_D,
  parameter int unsigned DEPTH = PC_LUT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addr,
  output logic [D-1:0]      target,
  output logic              busy,
  output logic              load_done,
  output logic              err
);

  localparam int unsigned CMP_W = ADDR_W + 1;

`ifdef PC_LUT_LOADER_CSUM_EN
  localparam loader_state_t END_ST = ST_CSUM;
`else
  localparam loader_state_t END_ST = ST_DONE;
`endif

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]        lo_q, lo_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              load_done_q, load_done_d;
  logic              in_ready_q, in_ready_d;
`ifdef PC_LUT_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              xfer_c;
  logic              we_c;
  logic              clr_c;
  logic              hi_ovf_c;
  logic              n_big_c;
  logic [15:0]       hi_word_c;
  logic [D-1:0]      wdata_c;

  assign xfer_c    = in_valid && in_ready_q;
  assign hi_word_c = {in_data, 8'h00};
  // Any HI-byte bit that lands at or above bit D cannot be stored
  assign hi_ovf_c  = ((hi_word_c >> D) != 16'h0000);
  assign n_big_c   = ({1'b0, in_data} > CMP_W'(DEPTH));
  assign wdata_c   = D'({in_data, lo_q});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_idx_d  = wr_idx_q;
    lo_d      = lo_q;
    err_d     = err_q;
    we_c      = 1'b0;
    clr_c     = 1'b0;
`ifdef PC_LUT_LOADER_CSUM_EN
    csum_d    = csum_q;
`endif

    if (start) begin
      state_d  = ST_COUNT;
      cnt_d    = '0;
      wr_idx_d = '0;
      err_d    = 1'b0;
      clr_c    = 1'b1;
`ifdef PC_LUT_LOADER_CSUM_EN
      csum_d   = 8'h00;
`endif
    end else if (xfer_c) begin
`ifdef PC_LUT_LOADER_CSUM_EN
      csum_d = csum_q ^ in_data;
`endif
      unique case (state_q)
        ST_COUNT: begin
          if (in_data == 8'h00) begin
            state_d = END_ST;
          end else if (n_big_c) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d   = in_data;
            state_d = ST_LO;
          end
        end
        ST_LO: begin
          lo_d    = in_data;
          state_d = ST_HI;
        end
        ST_HI: begin
          we_c     = 1'b1;
          err_d    = err_q | hi_ovf_c;
          wr_idx_d = wr_idx_q + 8'd1;
          cnt_d    = cnt_q - 8'd1;
          state_d  = (cnt_q == 8'd1) ? END_ST : ST_LO;
        end
`ifdef PC_LUT_LOADER_CSUM_EN
        // Compare against the running XOR taken before this byte
        ST_CSUM: begin
          err_d   = err_q | (in_data != csum_q);
          state_d = ST_DONE;
        end
`endif
        default: begin
          state_d = state_q;
        end
      endcase
    end

    in_ready_d  = accepts_bytes(state_d);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
    load_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_idx_q    <= '0;
      lo_q        <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef PC_LUT_LOADER_CSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_idx_q    <= wr_idx_d;
      lo_q        <= lo_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      in_ready_q  <= in_ready_d;
`ifdef PC_LUT_LOADER_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  pc_lut_store #(
    .D     (D),
    .DEPTH (DEPTH)
  ) u_store (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_c),
    .we    (we_c),
    .waddr (wr_idx_q),
    .wdata (wdata_c),
    .raddr (addr),
    .rdata (target)
  );

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pc_lut_loader.sv
// Self-checking bench for pc_lut_loader: directed and randomized byte streams
// checked against a stream-decoding reference model.
module tb_pc_lut_loader;
  import pc_lut_pkg::*;

  localparam int unsigned D     = PC_LUT_D;
  localparam int unsigned DEPTH = PC_LUT_DEPTH;
  localparam int          READY_BOUND = 50;

  typedef logic [7:0] byte_q_t[$];

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [7:0]   addr;
  logic [D-1:0] target;
  logic         busy;
  logic         load_done;
  logic         err;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned exp_tbl [DEPTH];
  bit          exp_err;

  always #5 clk = ~clk;

  pc_lut_loader #(
    .D     (D),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .addr      (addr),
    .target    (target),
    .busy      (busy),
    .load_done (load_done),
    .err       (err)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: decode a complete stream into the final table and error flag
  task automatic run_model(input byte_q_t s);
    int          n;
    int unsigned val;
    logic [7:0]  x;
    for (int i = 0; i < int'(DEPTH); i++) exp_tbl[i] = 0;
    exp_err = 1'b0;
    n = int'(s[0]);
    if (n > int'(DEPTH)) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      val = int'(s[1 + 2*i]) + 256 * int'(s[2 + 2*i]);
      if (val >= (1 << D)) exp_err = 1'b1;
      exp_tbl[i] = val % (1 << D);
    end
`ifdef PC_LUT_LOADER_CSUM_EN
    x = 8'h00;
    for (int j = 0; j <= 2*n; j++) x = x ^ s[j];
    if (s[1 + 2*n] != x) exp_err = 1'b1;
`else
    x = 8'h00;
    if (x != 8'h00) exp_err = 1'b1;
`endif
  endtask

  task automatic add_csum(inout byte_q_t s, input bit bad);
`ifdef PC_LUT_LOADER_CSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (s[i]) x = x ^ s[i];
    if (bad) x = x ^ 8'(1 + $urandom_range(254, 0));
    s.push_back(x);
`else
    if (bad && s.size() == 0) s.push_back(8'h00);
`endif
  endtask

  task automatic gen_stream(output byte_q_t s, input int n, input bit allow_ovf, input bit bad_csum);
    s = {};
    s.push_back(8'(n));
    if (n > int'(DEPTH)) return;
    for (int i = 0; i < n; i++) begin
      s.push_back(8'($urandom));
      if (allow_ovf && $urandom_range(5, 0) == 0) s.push_back(8'($urandom));
      else s.push_back(8'($urandom_range((1 << (D - 8)) - 1, 0)));
    end
    add_csum(s, bad_csum);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int waited;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < READY_BOUND) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_stream(input byte_q_t s, input int max_gap);
    foreach (s[i]) send_byte(s[i], max_gap);
  endtask

  task automatic check_table(input string tag);
    for (int a = 0; a < int'(DEPTH); a++) begin
      addr = 8'(a);
      #1 check($sformatf("%s_tbl%0d", tag, a), 32'(target), exp_tbl[a]);
    end
    addr = 8'(DEPTH);
    #1 check($sformatf("%s_oob", tag), 32'(target), 0);
    addr = 8'hFF;
    #1 check($sformatf("%s_oobff", tag), 32'(target), 0);
  endtask

  task automatic check_status(input string tag, input bit e_done, input bit e_busy,
                              input bit e_rdy, input bit e_err);
    check({tag, "_done"},  32'(load_done), 32'(e_done));
    check({tag, "_busy"},  32'(busy),      32'(e_busy));
    check({tag, "_ready"}, 32'(in_ready),  32'(e_rdy));
    check({tag, "_err"},   32'(err),       32'(e_err));
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(DEPTH); i++) exp_tbl[i] = 0;
    exp_err = 1'b0;
  endtask

  initial begin
    byte_q_t s;
    byte_q_t head;
    logic [7:0] last;
    int n;

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    addr     = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    clear_model();
    check_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_table("rst");

    // Directed stream, no bubbles; load_done only after the final byte
    s = '{8'h03, 8'h0B, 8'h00, 8'h08, 8'h00, 8'h1D, 8'h01};
    add_csum(s, 1'b0);
    run_model(s);
    check("dir_model_e2", exp_tbl[2], 285);
    head = s;
    last = head.pop_back();
    pulse_start();
    check_status("dir_started", 1'b0, 1'b1, 1'b1, 1'b0);
    send_stream(head, 0);
    @(negedge clk);
    check_status("dir_prelast", 1'b0, 1'b1, 1'b1, 1'b0);
    send_byte(last, 0);
    @(negedge clk);
    check_status("dir_end", 1'b1, 1'b0, 1'b0, exp_err);
    check_table("dir");

    // Same stream with random bubbles
    pulse_start();
    send_stream(s, 5);
    @(negedge clk);
    check_status("bub_end", 1'b1, 1'b0, 1'b0, exp_err);
    check_table("bub");

    // Oversized header: error, straight to DONE, nothing written
    s = '{8'(DEPTH + 1)};
    run_model(s);
    pulse_start();
    send_stream(s, 2);
    @(negedge clk);
    check_status("big", 1'b1, 1'b0, 1'b0, exp_err);
    check_table("big");

    // HI byte with bits beyond D: truncated and flagged
    s = '{8'h02, 8'h34, 8'h05, 8'h56, 8'h02};
    add_csum(s, 1'b0);
    run_model(s);
    pulse_start();
    send_stream(s, 3);
    @(negedge clk);
    check_status("ovf", 1'b1, 1'b0, 1'b0, exp_err);
    check_table("ovf");

    // Restart coincident with the HI byte of entry 5
    gen_stream(s, 8, 1'b0, 1'b0);
    run_model(s);
    head = {};
    for (int i = 0; i < 1 + 2*5 + 1; i++) head.push_back(s[i]);
    pulse_start();
    send_stream(head, 2);
    @(negedge clk);
    addr = 8'd4;
    #1 check("mid_e4_visible", 32'(target), exp_tbl[4]);
    addr = 8'd5;
    #1 check("mid_e5_unwritten", 32'(target), 0);
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = s[12];
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    clear_model();
    check_status("restart", 1'b0, 1'b1, 1'b1, 1'b0);
    check_table("restart");
    s = '{8'h01, 8'hAA, 8'h01};
    add_csum(s, 1'b0);
    run_model(s);
    send_stream(s, 2);
    @(negedge clk);
    check_status("restart_load", 1'b1, 1'b0, 1'b0, exp_err);
    check_table("restart_load");

    // Reset in the middle of a load drops everything at once
    gen_stream(s, 6, 1'b0, 1'b0);
    head = {};
    for (int i = 0; i < 7; i++) head.push_back(s[i]);
    pulse_start();
    send_stream(head, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    clear_model();
    check_status("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_table("midrst");
    @(negedge clk);
    reset = 1'b0;

    // Long stall keeps the loader waiting in place
    s = '{8'h01, 8'h10, 8'h00};
    add_csum(s, 1'b0);
    run_model(s);
    pulse_start();
    send_byte(s[0], 0);
    repeat (20) @(negedge clk);
    check_status("stall", 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < s.size(); i++) send_byte(s[i], 0);
    @(negedge clk);
    check_status("stall_end", 1'b1, 1'b0, 1'b0, exp_err);
    check_table("stall");

`ifdef PC_LUT_LOADER_CSUM_EN
    s = '{8'h01, 8'h48, 8'h01, 8'h48};
    run_model(s);
    pulse_start();
    send_stream(s, 2);
    @(negedge clk);
    check_status("csum_ok", 1'b1, 1'b0, 1'b0, 1'b0);
    check_table("csum_ok");
    s = '{8'h01, 8'h48, 8'h01, 8'h00};
    run_model(s);
    pulse_start();
    send_stream(s, 2);
    @(negedge clk);
    check_status("csum_bad", 1'b1, 1'b0, 1'b0, 1'b1);
    check_table("csum_bad");
`endif

    // Randomized loads
    for (int it = 0; it < 14; it++) begin
      if (it == 0) n = 0;
      else if (it == 1) n = int'(DEPTH);
      else n = int'($urandom_range(DEPTH + 2, 0));
      gen_stream(s, n, ($urandom_range(2, 0) == 0), ($urandom_range(3, 0) == 0));
      run_model(s);
      pulse_start();
      send_stream(s, 5);
      @(negedge clk);
      check_status($sformatf("rnd%0d", it), 1'b1, 1'b0, 1'b0, exp_err);
      check_table($sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
